// File: rtl/tdm_demux_pkg.sv
// tdm_pkg: shared sizes and FSM state type for the TDM demultiplexer.
package tdm_pkg;
  localparam int N_CH = 4;
  localparam int W = 8;
  localparam int MISS_MAX = 2;
  localparam int FRAME_BITS = N_CH * W;
  localparam int BW = $clog2(W);
  localparam int SW = $clog2(N_CH);
  localparam int MW = $clog2(MISS_MAX + 1);
  localparam int FW = $clog2(FRAME_BITS);
  typedef enum logic {HUNT, LOCK} state_e;
endpackage

// File: rtl/tdm_demux_if.sv
// tdm_demux_if: serial link input and recovered parallel frame outputs.
interface tdm_demux_if;
  import tdm_pkg::*;
  logic din;
  logic din_en;
  logic fs;
  logic [FRAME_BITS-1:0] ch_data;
  logic ch_valid;
  logic locked;
  logic sync_err;
  modport master (output din, din_en, fs, input ch_data, ch_valid, locked, sync_err);
  modport slave (input din, din_en, fs, output ch_data, ch_valid, locked, sync_err);
endinterface

// File: rtl/tdm_demux_slot_counter.sv
// tdm_slot_counter: bit/slot position counters; clr_i restarts counting from bit 0 of slot 0.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [BW-1:0] bit_o,
  output logic [SW-1:0] slot_o,
  output logic          last_bit_o,
  output logic          last_slot_o,
  output logic          frame_start_o
);
  logic [BW-1:0] bit_q, bit_d, b;
  logic [SW-1:0] slot_q, slot_d, s;
  always_comb begin
    b = clr_i ? '0 : bit_q;
    s = clr_i ? '0 : slot_q;
    bit_d = (b == BW'(W - 1)) ? '0 : b + 1'b1;
    slot_d = (b != BW'(W - 1)) ? s : (s == SW'(N_CH - 1)) ? '0 : s + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q <= '0;
      slot_q <= '0;
    end else if (en_i) begin
      bit_q <= bit_d;
      slot_q <= slot_d;
    end
  end
  assign bit_o = bit_q;
  assign slot_o = slot_q;
  assign last_bit_o = bit_q == BW'(W - 1);
  assign last_slot_o = slot_q == SW'(N_CH - 1);
  assign frame_start_o = (bit_q == '0) && (slot_q == '0);
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: splits a framed single-bit TDM stream back into N_CH parallel channel words.
module tdm_demux
  import tdm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  tdm_demux_if.slave lnk
);
  state_e                state_q;
  logic [MW-1:0]         miss_q;
  logic [FRAME_BITS-1:0] cap_q, cap_d, ch_data_q;
  logic                  ch_valid_q, locked_q, sync_err_q;
  logic [BW-1:0]         bit_c, bit_b;
  logic [SW-1:0]         slot_c, slot_b;
  logic                  last_bit, last_slot, frame_start;
  logic                  hunt, err, drop, acc, clr, done;
  logic [FW-1:0]         idx;
  tdm_slot_counter u_cnt (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_i          (acc),
    .clr_i         (clr),
    .bit_o         (bit_c),
    .slot_o        (slot_c),
    .last_bit_o    (last_bit),
    .last_slot_o   (last_slot),
    .frame_start_o (frame_start)
  );
  // Any accepted bit while hunting or on a resync is slot 0 bit 0, so the position base is cleared
  always_comb begin
    hunt = state_q == HUNT;
    err = !hunt && lnk.din_en && lnk.fs && !frame_start;
    drop = !hunt && lnk.din_en && !lnk.fs && frame_start && (miss_q == MW'(MISS_MAX - 1));
    acc = lnk.din_en && (hunt ? lnk.fs : !drop);
    clr = hunt || err;
    done = acc && !clr && last_bit && last_slot;
    bit_b = clr ? '0 : bit_c;
    slot_b = clr ? '0 : slot_c;
    idx = FW'(slot_b) * FW'(W) + FW'(W - 1) - FW'(bit_b);
    cap_d = cap_q;
    cap_d[idx] = acc ? lnk.din : cap_q[idx];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      miss_q <= '0;
      cap_q <= '0;
      ch_data_q <= '0;
      ch_valid_q <= 1'b0;
      locked_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      cap_q <= cap_d;
      ch_valid_q <= done;
      sync_err_q <= err;
      if (done) ch_data_q <= cap_d;
      if (hunt && acc) begin
        state_q <= LOCK;
        locked_q <= 1'b1;
        miss_q <= '0;
      end else if (drop) begin
        state_q <= HUNT;
        locked_q <= 1'b0;
        miss_q <= '0;
      end else if (!hunt && lnk.din_en && frame_start) begin
        miss_q <= lnk.fs ? '0 : miss_q + 1'b1;
      end
    end
  end
  assign lnk.ch_data = ch_data_q;
  assign lnk.ch_valid = ch_valid_q;
  assign lnk.locked = locked_q;
  assign lnk.sync_err = sync_err_q;
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed checks of lock, frame capture, flywheel, resync and reset behaviour.
module tb_tdm_demux;
  import tdm_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vec = 0;
  int miss = 0;
  int vcnt = 0;
  int ecnt = 0;
  logic first_lock, first_err;
  always #5 clk = ~clk;
  tdm_demux_if lnk ();
  tdm_demux dut (.clk(clk), .rst_n(rst_n), .lnk(lnk));
  always @(negedge clk) begin
    if (lnk.ch_valid) vcnt++;
    if (lnk.sync_err) ecnt++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic d, input logic e, input logic f);
    @(negedge clk);
    lnk.din = d;
    lnk.din_en = e;
    lnk.fs = f;
  endtask
  // Sends n bits of fr in line order (slot 0 first, MSB first); fsm[k] is fs on bit k
  task automatic send(input logic [31:0] fr, input int n, input logic [31:0] fsm, input bit gap);
    for (int k = 0; k < n; k++) begin
      if (gap) step(~fr[(k / 8) * 8 + 7 - k % 8], 1'b0, 1'b1);
      step(fr[(k / 8) * 8 + 7 - k % 8], 1'b1, fsm[k]);
      @(posedge clk);
      #1;
      if (k == 0) begin
        first_lock = lnk.locked;
        first_err = lnk.sync_err;
      end
    end
  endtask
  initial begin
    lnk.din = 1'b0;
    lnk.din_en = 1'b0;
    lnk.fs = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_locked", lnk.locked, 0);
    chk("reset_valid", lnk.ch_valid, 0);
    chk("reset_err", lnk.sync_err, 0);
    chk("reset_data", lnk.ch_data, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 50; i++) step(i[0], 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("idle_locked", lnk.locked, 0);
    chk("idle_vcnt", vcnt, 0);
    chk("idle_data", lnk.ch_data, 0);
    send(32'h01FF3CA5, 32, 32'h1, 1'b0);
    chk("a_lock", first_lock, 1);
    chk("a_valid", lnk.ch_valid, 1);
    chk("a_data", lnk.ch_data, 32'h01FF3CA5);
    chk("a_early", vcnt, 0);
    step(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("a_pulse", lnk.ch_valid, 0);
    chk("a_vcnt", vcnt, 1);
    send(32'h8001C37E, 32, 32'h1, 1'b0);
    chk("c_valid", lnk.ch_valid, 1);
    chk("c_data", lnk.ch_data, 32'h8001C37E);
    send(32'h01FF3CA5, 32, 32'h1, 1'b1);
    chk("g_valid", lnk.ch_valid, 1);
    chk("g_data", lnk.ch_data, 32'h01FF3CA5);
    step(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("g_pulse", lnk.ch_valid, 0);
    chk("g_vcnt", vcnt, 3);
    send(32'hDEADBEEF, 13, 32'h1, 1'b0);
    chk("e_held", lnk.ch_data, 32'h01FF3CA5);
    chk("e_noval", vcnt, 3);
    send(32'h44332211, 32, 32'h1, 1'b0);
    chk("x_err", first_err, 1);
    chk("x_valid", lnk.ch_valid, 1);
    chk("x_data", lnk.ch_data, 32'h44332211);
    step(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("x_ecnt", ecnt, 1);
    chk("x_vcnt", vcnt, 4);
    send(32'hCAFEBABE, 32, 32'h0, 1'b0);
    chk("f2_lock", first_lock, 1);
    chk("f2_valid", lnk.ch_valid, 1);
    chk("f2_data", lnk.ch_data, 32'hCAFEBABE);
    send(32'h13579BDF, 32, 32'h0, 1'b0);
    chk("f3_unlock", first_lock, 0);
    chk("f3_locked", lnk.locked, 0);
    chk("f3_vcnt", vcnt, 5);
    chk("f3_data", lnk.ch_data, 32'hCAFEBABE);
    send(32'h0F1E2D3C, 32, 32'h1, 1'b0);
    chk("r_lock", first_lock, 1);
    chk("r_data", lnk.ch_data, 32'h0F1E2D3C);
    send(32'h12345678, 32, 32'h80000001, 1'b0);
    chk("l_err", lnk.sync_err, 1);
    chk("l_noval", lnk.ch_valid, 0);
    chk("l_data", lnk.ch_data, 32'h0F1E2D3C);
    chk("l_locked", lnk.locked, 1);
    chk("l_ecnt", ecnt, 1);
    send(32'hFFFF0000, 20, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    lnk.din_en = 1'b0;
    lnk.fs = 1'b0;
    #1;
    chk("rst_data", lnk.ch_data, 0);
    chk("rst_locked", lnk.locked, 0);
    chk("rst_valid", lnk.ch_valid, 0);
    chk("rst_err", lnk.sync_err, 0);
    @(negedge clk) rst_n = 1'b1;
    send(32'h9ABCDEF0, 32, 32'h1, 1'b0);
    chk("p_lock", first_lock, 1);
    chk("p_valid", lnk.ch_valid, 1);
    chk("p_data", lnk.ch_data, 32'h9ABCDEF0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive side of the team's serial multiplexed link: a single-bit time-division stream, framed by a sync strobe, is split back into N_CH parallel channel words.
- Complements the mux datapath: the transmitter interleaves channels onto one wire, and this block re-separates them.
- Sits between the serial link input and the per-channel consumers; a registered frame is presented with a one-cycle valid pulse.

Parameters:
- N_CH, 4, number of channels (time slots) per frame, >=2
- W, 8, bits per channel slot, >=2
- MISS_MAX, 2, consecutive missing frame syncs tolerated before lock is dropped, >=1

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- din  input  1  serial data bit, MSB of each slot first
- din_en  input  1  din/fs valid this cycle; counters advance only when high
- fs  input  1  frame sync, qualified by din_en; marks bit 0 of slot 0
- ch_data  output  N_CH*W  last complete frame; channel i at ch_data[i*W +: W]; slot 0 is first in time
- ch_valid  output  1  one-cycle pulse when ch_data updates
- locked  output  1  high while in LOCK state
- sync_err  output  1  one-cycle pulse on an fs seen at an unexpected position

Behaviour:
- Reset (async, rst_n=0): state=HUNT; bit_cnt=0, slot_cnt=0, miss_cnt=0; capture register=0; ch_data=0; ch_valid=0; locked=0; sync_err=0. All outputs are registered.
- din_en=0: nothing changes, and ch_valid/sync_err are 0 that cycle.
- HUNT: bits are discarded until din_en&fs. That bit is stored as bit 0 (MSB) of slot 0, bit_cnt becomes 1, state becomes LOCK, locked=1 from the next cycle, and miss_cnt=0.
- LOCK, din_en=1:
  - The bit shifts into the current slot's capture word, MSB-first.
  - bit_cnt wraps W-1 -> 0 and increments slot_cnt.
  - slot_cnt wraps N_CH-1 -> 0.
- Frame complete: the bit accepted with bit_cnt=W-1 and slot_cnt=N_CH-1 is the final bit.
  - On that edge, ch_data loads the full capture (including that bit).
  - ch_valid=1 for exactly the following cycle.
  - Latency is 1 cycle from the final-bit sampling edge to ch_valid.
- Expected fs: fs on the bit where bit_cnt=0 and slot_cnt=0. No error; miss_cnt=0.
- Missing fs at a frame start (din_en=1, fs=0, counters 0/0):
  - Flywheel: the bit is accepted as bit 0 of slot 0 and miss_cnt increments.
  - If miss_cnt reaches MISS_MAX: return to HUNT, locked=0 next cycle, and that bit is discarded.
- Unexpected fs (fs=1 at any other position in LOCK):
  - sync_err pulses 1 cycle and the partial frame is discarded; ch_valid is not asserted and ch_data is held.
  - The bit is taken as bit 0 of slot 0 (immediate resync); counters restart, bit_cnt=1, slot_cnt=0, and state stays LOCK.
- An unexpected fs coinciding with the final-bit position: the error wins; the frame is discarded and there is no ch_valid.
- ch_data holds its value through HUNT and errors until the next complete frame.
- Reset mid-frame: the partial frame is lost and all outputs go to reset values immediately.

Decomposition:
- Package tdm_pkg holds:
  - the state enum {HUNT, LOCK}
  - localparam FRAME_BITS = N_CH*W
  - counter widths $clog2(W), $clog2(N_CH) and $clog2(MISS_MAX+1)
- One sub-module, tdm_slot_counter: the bit/slot counter pair with enable, sync clear, and wrap flags (last_bit, last_slot, frame_start). The top level holds the FSM, the capture shift register and the output registers.

Test Plan (N_CH=4, W=8, MISS_MAX=2, din_en=1 continuous unless stated):
- Reset then idle with fs=0 for 50 cycles -> locked=0, ch_valid never asserts, ch_data=0.
- fs on first bit, stream bytes 0xA5,0x3C,0xFF,0x01 -> locked=1 from cycle 2, single ch_valid pulse 1 cycle after bit 32, ch_data=0x01FF3CA5.
- Same frame with din_en toggling 1/0 each cycle -> identical ch_data. ch_valid comes 1 cycle after the 32nd enabled bit, and no counter advances on din_en=0 cycles.
- Lock, then fs asserted at bit 13 -> sync_err pulse 1 cycle, no ch_valid, ch_data unchanged. The next 32 bits after that fs (bytes 0x11,0x22,0x33,0x44) -> ch_data=0x44332211.
- Lock, then omit fs for frame 2 -> frame 2 is still delivered with locked=1. Omitting fs for frame 3 as well -> locked=0 at the start of frame 3, with no ch_valid for frame 3.
- Assert rst_n=0 mid-frame (bit 20) for 1 cycle -> all outputs 0 asynchronously. A subsequent fs gives a clean lock with the correct frame.
